// File: rtl/i2s_playback_feeder.sv
// Stereo sample FIFO feeding an I2S transmitter in the mclk domain.
// One L/R pair is presented per frame; the next pair is popped on each ws falling edge.
module i2s_playback_feeder #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned PRIME_LEVEL   = 32,
    parameter int unsigned UNDERRUN_HOLD = 0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     i_mclk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_data_l,
    input  logic [WIDTH-1:0]         i_in_data_r,
    input  logic                     i_flush,
    input  logic                     i_ws,
    output logic [WIDTH-1:0]         o_tx_data_l,
    output logic [WIDTH-1:0]         o_tx_data_r,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_running,
    output logic [CNT_WIDTH-1:0]     o_underrun_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {StFill, StRun} state_t;

    state_t              r_state;
    logic                r_ws_q;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic [WIDTH-1:0]    r_tx_l;
    logic [WIDTH-1:0]    r_tx_r;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2*WIDTH-1:0]  r_mem [DEPTH];

    logic                w_fe;
    logic                w_push;
    logic                w_pop;
    logic                w_underrun;
    logic                w_have;
    logic                w_primed;
    logic [2*WIDTH-1:0]  w_head;

    always_comb begin
        w_fe       = r_ws_q & ~i_ws;
        o_in_ready = (r_level < LW'(DEPTH)) & ~i_flush;
        w_push     = i_in_valid & o_in_ready;
        w_have     = (r_level != '0);
        w_primed   = (r_level >= LW'(PRIME_LEVEL));
        // In FILL the first pop only happens once the prime level is reached.
        w_pop      = w_fe & w_have & ((r_state == StRun) | w_primed);
        w_underrun = w_fe & (r_state == StRun) & ~w_have;
        w_head     = r_mem[r_rd_ptr];
    end

    always_ff @(posedge i_mclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_data_l, i_in_data_r};
        end
    end

    always_ff @(posedge i_mclk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StFill;
            r_ws_q   <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_tx_l   <= '0;
            r_tx_r   <= '0;
            r_cnt    <= '0;
        end else begin
            r_ws_q <= i_ws;
            if (i_flush) begin
                r_state  <= StFill;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_tx_l   <= '0;
                r_tx_r   <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_tx_l   <= w_head[2*WIDTH-1:WIDTH];
                    r_tx_r   <= w_head[WIDTH-1:0];
                    r_state  <= StRun;
                end
                if (w_underrun) begin
                    r_state <= StFill;
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (UNDERRUN_HOLD == 0) begin
                        r_tx_l <= '0;
                        r_tx_r <= '0;
                    end
                end
                r_level <= r_level + LW'(w_push) - LW'(w_pop);
            end
        end
    end

    assign o_tx_data_l    = r_tx_l;
    assign o_tx_data_r    = r_tx_r;
    assign o_level        = r_level;
    assign o_running      = (r_state == StRun);
    assign o_underrun_cnt = r_cnt;

endmodule

// File: tb/tb_i2s_playback_feeder.sv
// Bench for i2s_playback_feeder: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations, on a zero-fill and a hold instance.
module tb_i2s_playback_feeder;

    localparam int DEPTH = 64;
    localparam int PRIME = 32;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        flush = 1'b0;
    logic        ws = 1'b1;

    logic        rdy0, rdy1, run0, run1;
    logic [15:0] txl0, txr0, txl1, txr1, cnt0, cnt1;
    logic [6:0]  lvl0, lvl1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0] q[$];
    bit          m_run;
    logic [31:0] m_tx0, m_tx1;
    logic [15:0] m_cnt;
    bit          m_wsq;

    always #5 mclk = ~mclk;

    i2s_playback_feeder #(.WIDTH(16), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME),
                          .UNDERRUN_HOLD(0), .CNT_WIDTH(16)) u_dut0 (
        .i_mclk(mclk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
        .i_in_data_l(in_l), .i_in_data_r(in_r), .i_flush(flush), .i_ws(ws),
        .o_tx_data_l(txl0), .o_tx_data_r(txr0), .o_level(lvl0),
        .o_running(run0), .o_underrun_cnt(cnt0)
    );

    i2s_playback_feeder #(.WIDTH(16), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME),
                          .UNDERRUN_HOLD(1), .CNT_WIDTH(16)) u_dut1 (
        .i_mclk(mclk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_in_data_l(in_l), .i_in_data_r(in_r), .i_flush(flush), .i_ws(ws),
        .o_tx_data_l(txl1), .o_tx_data_r(txr1), .o_level(lvl1),
        .o_running(run1), .o_underrun_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 1'b0;
        m_tx0 = '0;
        m_tx1 = '0;
        m_cnt = '0;
        m_wsq = 1'b1;
    endtask

    // Advance one mclk edge; the model consumes the inputs that were stable before the edge.
    task automatic tick();
        bit          fe;
        int          sz;
        logic [31:0] head;
        @(posedge mclk);
        fe = m_wsq && !ws;
        sz = q.size();
        if (rst) begin
            model_reset();
        end else begin
            m_wsq = ws;
            if (flush) begin
                q.delete();
                m_run = 1'b0;
                m_tx0 = '0;
                m_tx1 = '0;
            end else begin
                if (fe) begin
                    if (m_run && sz == 0) begin
                        if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
                        m_tx0 = '0;
                        m_run = 1'b0;
                    end else if (m_run || sz >= PRIME) begin
                        head  = q.pop_front();
                        m_tx0 = head;
                        m_tx1 = head;
                        m_run = 1'b1;
                    end
                end
                if (in_valid && sz < DEPTH) q.push_back({in_l, in_r});
            end
        end
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_l = l;
        in_r = r;
        tick();
        in_valid = 1'b0;
    endtask

    // One I2S frame: left half (ws=0 after the falling edge) then right half.
    task automatic frame();
        ws = 1'b0;
        repeat (4) tick();
        ws = 1'b1;
        repeat (4) tick();
    endtask

    always @(negedge mclk) begin
        if (chk_en) begin
            chk("level", {25'd0, lvl0}, q.size());
            chk("level_h", {25'd0, lvl1}, q.size());
            chk("in_ready", {31'd0, rdy0}, {31'd0, (q.size() < DEPTH) && !flush});
            chk("running", {30'd0, run1, run0}, {30'd0, m_run, m_run});
            chk("tx_zero", {txl0, txr0}, m_tx0);
            chk("tx_hold", {txl1, txr1}, m_tx1);
            chk("cnt", {cnt1, cnt0}, {m_cnt, m_cnt});
        end
    end

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_level", {25'd0, lvl0}, 32'd0);
        chk("rst_tx", {txl0, txr0}, 32'd0);
        chk("rst_run_cnt", {15'd0, run0, cnt0}, 32'd0);

        // Prime: 31 pairs are not enough to start playback
        for (int k = 0; k < 31; k++) push(16'h1111, 16'h2222);
        repeat (3) frame();
        chk("prime_wait_tx", {txl0, txr0}, 32'd0);
        chk("prime_wait_run", {31'd0, run0}, 32'd0);
        push(16'h1111, 16'h2222);
        frame();
        chk("prime_tx", {txl0, txr0}, 32'h1111_2222);
        chk("prime_run", {31'd0, run0}, 32'd1);
        chk("prime_level", {25'd0, lvl0}, 32'd31);

        // Flush in RUN at level 20
        repeat (11) frame();
        chk("pre_flush_level", {25'd0, lvl0}, 32'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", {25'd0, lvl0}, 32'd0);
        chk("flush_tx", {txl1, txr1}, 32'd0);
        chk("flush_run_cnt", {15'd0, run0, cnt0}, 32'd0);

        // Ordering: L=k, R=~k
        for (int k = 0; k < 32; k++) push(16'(k), ~16'(k));
        for (int k = 0; k < 32; k++) begin
            frame();
            chk("order_l", {16'd0, txl0}, k);
            chk("order_r", {16'd0, txr0}, {16'd0, ~16'(k)});
        end
        chk("order_level", {25'd0, lvl0}, 32'd0);

        // Underrun: zero instance clears, hold instance keeps pair 31
        frame();
        chk("ur_tx_zero", {txl0, txr0}, 32'd0);
        chk("ur_tx_hold", {txl1, txr1}, 32'h001f_ffe0);
        chk("ur_cnt", {16'd0, cnt0}, 32'd1);
        chk("ur_run", {30'd0, run1, run0}, 32'd0);

        // Full: 64 pairs, then a held 65th pair
        for (int k = 0; k < 64; k++) push(16'(k + 256), 16'(k + 512));
        chk("full_level", {25'd0, lvl0}, 32'd64);
        chk("full_ready", {31'd0, rdy0}, 32'd0);
        in_valid = 1'b1;
        in_l = 16'haaaa;
        in_r = 16'h5555;
        repeat (2) tick();
        chk("full_ignored", {25'd0, lvl0}, 32'd64);
        frame();
        in_valid = 1'b0;
        chk("full_refill", {25'd0, lvl0}, 32'd64);
        chk("full_tx", {txl0, txr0}, 32'h0100_0200);

        // Async reset mid-frame with level 10
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 10; k++) push(16'(k + 7), 16'(k + 9));
        chk("pre_rst_level", {25'd0, lvl0}, 32'd10);
        ws = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_level", {25'd0, lvl0}, 32'd0);
        chk("arst_tx", {txl1, txr1}, 32'd0);
        chk("arst_cnt", {16'd0, cnt0}, 32'd0);
        ws = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) push(16'h0bad, 16'hcafe);
        repeat (3) tick();
        chk("no_false_fe", {31'd0, run0}, 32'd0);
        frame();
        chk("post_rst_tx", {txl0, txr0}, 32'h0bad_cafe);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
